// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if
//   Groups the burst-control, RAM read-port and output-stream signals of
//   ram_stream_reader.
//   Control    : start, start_address, word_count -> reader; busy, done <- reader
//   RAM port   : ram_read_address <- reader; ram_read_data -> reader
//                (RAM returns data one cycle after the address, no enable)
//   Stream     : out_valid, out_data, out_last <- reader; out_ready -> reader
//   Modports   : slave  = the reader itself
//                master = the environment (controller, RAM and sink)
interface ram_stream_reader_if #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10
);
  logic                     start;
  logic [ADDRESS_WIDTH-1:0] start_address;
  logic [ADDRESS_WIDTH:0]   word_count;
  logic                     busy;
  logic                     done;
  logic [ADDRESS_WIDTH-1:0] ram_read_address;
  logic [WORD_WIDTH-1:0]    ram_read_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [WORD_WIDTH-1:0]    out_data;
  logic                     out_last;

  modport slave (
    input  start, start_address, word_count, ram_read_data, out_ready,
    output busy, done, ram_read_address, out_valid, out_data, out_last
  );

  modport master (
    output start, start_address, word_count, ram_read_data, out_ready,
    input  busy, done, ram_read_address, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Reads a burst of word_count consecutive RAM words starting at
//   start_address (address wraps modulo 2**ADDRESS_WIDTH) and streams them
//   out on a valid/ready interface, marking the final word with out_last.
//   A 2-entry output FIFO absorbs the one-cycle RAM latency so the stream
//   sustains one word per cycle while out_ready stays high and never drops
//   or duplicates a word under backpressure.
//   Ports:
//     clock  - rising-edge clock
//     reset  - synchronous active-high reset (aborts any burst)
//     bus    - ram_stream_reader_if.slave (control, RAM read port, stream)
module ram_stream_reader #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10
) (
  input logic                clock,
  input logic                reset,
  ram_stream_reader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [1:0]               OCC_ONE  = 2'd1;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] addr_p0;
  logic [ADDRESS_WIDTH:0]   remaining;
  logic                     vld_p1;
  logic                     last_p1;
  logic [WORD_WIDTH-1:0]    fifo_data [2];
  logic                     fifo_last [2];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               occupancy;
  logic                     out_valid;
  logic                     transfer;
  logic                     issue;
  logic                     start_burst;
  logic [2:0]               pending;
  logic [2:0]               limit;

  assign out_valid   = (occupancy != 2'd0);
  assign transfer    = out_valid && bus.out_ready;
  assign start_burst = (state == IDLE) && bus.start;

  // A read may be issued only if the FIFO is guaranteed a free slot when its
  // data returns next cycle: words held plus words in flight, less the one
  // leaving this cycle, must stay below the FIFO depth.
  assign pending = {1'b0, occupancy} + {2'b00, vld_p1};
  assign limit   = 3'd2 + {2'b00, transfer};
  assign issue   = (state == STREAM) && (remaining != '0) && (pending < limit);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = (bus.word_count != '0) ? STREAM : FINISH;
      STREAM:  if (transfer && fifo_last[rd_ptr]) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy             = (state == STREAM);
    bus.done             = (state == FINISH);
    bus.ram_read_address = addr_p0;
    bus.out_valid        = out_valid;
    bus.out_data         = out_valid ? fifo_data[rd_ptr] : '0;
    bus.out_last         = out_valid && fifo_last[rd_ptr];
  end

  // ---- p0: address issue stage / control state ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      addr_p0   <= '0;
      remaining <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      state <= state_next;
      if (start_burst) begin
        addr_p0   <= bus.start_address;
        remaining <= bus.word_count;
      end else if (issue) begin
        addr_p0   <= addr_p0 + ADDR_ONE;
        remaining <= remaining - CNT_ONE;
      end
      vld_p1  <= issue;
      last_p1 <= issue && (remaining == CNT_ONE);
      if (vld_p1)   wr_ptr <= ~wr_ptr;
      if (transfer) rd_ptr <= ~rd_ptr;
      if (vld_p1 && !transfer)      occupancy <= occupancy + OCC_ONE;
      else if (!vld_p1 && transfer) occupancy <= occupancy - OCC_ONE;
    end
  end

  // ---- p1: RAM response captured into the output FIFO ----
  always_ff @(posedge clock) begin
    if (vld_p1) begin
      fifo_data[wr_ptr] <= bus.ram_read_data;
      fifo_last[wr_ptr] <= last_p1;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;
  localparam int WW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   max_occ  = 0;
  logic [WW-1:0] mem [DEPTH];

  ram_stream_reader_if #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) bus ();

  ram_stream_reader #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Synchronous RAM: data for the address seen at an edge appears after it.
  always @(posedge clock) bus.ram_read_data <= mem[bus.ram_read_address];

  always @(negedge clock) if (int'(dut.occupancy) > max_occ) max_occ = int'(dut.occupancy);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one burst from the IDLE cycle and returns in the IDLE cycle after FINISH.
  task automatic run_burst(input int sa, input int n, input bit rand_ready, input bit poke_start);
    logic [31:0] exp_q[$];
    logic [31:0] held_data;
    logic        held_last;
    int          c;
    int          got;
    bit          finished;
    bit          stalled;
    bit          seen_valid;
    logic [AW:0] n_vec;
    logic [AW-1:0] sa_vec;
    n_vec  = n[AW:0];
    sa_vec = sa[AW-1:0];
    for (int k = 0; k < n; k++) exp_q.push_back(mem[(sa + k) % DEPTH]);
    bus.start         = 1'b1;
    bus.start_address = sa_vec;
    bus.word_count    = n_vec;
    bus.out_ready     = 1'b1;
    step();
    bus.start = 1'b0;
    if (n == 0) begin
      check("zero_done", bus.done, 1);
      check("zero_busy", bus.busy, 0);
      check("zero_valid", bus.out_valid, 0);
      step();
      check("zero_done_single", bus.done, 0);
      check("zero_busy_after", bus.busy, 0);
      check("zero_valid_after", bus.out_valid, 0);
      return;
    end
    c = 0; got = 0; finished = 0; stalled = 0; seen_valid = 0;
    held_data = '0; held_last = 1'b0;
    while (!finished && c < 400) begin
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_start && c == 3) begin
        bus.start         = 1'b1;
        bus.start_address = 10'd300;
        bus.word_count    = 11'd7;
      end else begin
        bus.start = 1'b0;
      end
      check("busy", bus.busy, 1);
      check("done_early", bus.done, 0);
      if (stalled) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, held_data);
        check("stall_last", bus.out_last, held_last);
      end
      if (bus.out_valid && !seen_valid) begin
        seen_valid = 1;
        if (!rand_ready) check("first_valid_latency", c, 2);
      end
      stalled   = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      held_last = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", bus.out_valid, 0);
        end else begin
          check("data", bus.out_data, exp_q.pop_front());
          check("last", bus.out_last, exp_q.size() == 0);
        end
        if (!rand_ready) check("back_to_back", c, 2 + got);
        got++;
        if (bus.out_last) finished = 1;
      end
      step();
      c++;
    end
    bus.start = 1'b0;
    check("burst_timeout", finished, 1);
    check("transfer_count", got, n);
    check("done_pulse", bus.done, 1);
    check("finish_busy", bus.busy, 0);
    check("finish_valid", bus.out_valid, 0);
    step();
    check("done_single", bus.done, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    bit any_bad;
    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.start_address = '0;
    bus.word_count    = '0;
    bus.out_ready     = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = i;
    step();
    step();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_addr", bus.ram_read_address, 0);
    reset = 1'b0;
    step();

    // Reset wins over a simultaneous start.
    reset = 1'b1; bus.start = 1'b1; bus.start_address = 10'd9; bus.word_count = 11'd5;
    step();
    reset = 1'b0; bus.start = 1'b0;
    check("rst_prio_busy", bus.busy, 0);
    check("rst_prio_done", bus.done, 0);
    step();
    check("rst_prio_busy2", bus.busy, 0);

    // Identity RAM: data equals address.
    run_burst(5, 4, 0, 0);
    run_burst(1022, 4, 0, 0);
    run_burst(7, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    max_occ = 0;
    run_burst(int'($urandom_range(0, DEPTH - 1)), 16, 1, 0);
    check("fifo_bound", max_occ <= 2, 1);

    run_burst(50, 8, 0, 1);

    // Abort a 10-word burst three cycles in.
    bus.start = 1'b1; bus.start_address = 10'd200; bus.word_count = 11'd10; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_valid", bus.out_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_data", bus.out_data, 0);
    any_bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done || bus.out_valid || bus.busy) any_bad = 1;
    end
    check("abort_quiet", any_bad, 0);
    run_burst(1020, 10, 0, 0);

    max_occ = 0;
    for (int t = 0; t < 4; t++)
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 20)), 1, 0);
    check("fifo_bound_rand", max_occ <= 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
